// File: rtl/controlador_placar_if.sv
// controlador_placar_if: event, converter and display signals of the score sequencer
interface controlador_placar_if #(parameter int LARG = 7);
  logic            ponto_valido;
  logic            time_sel;
  logic [1:0]      valor;
  logic            corrigir;
  logic            zerar;
  logic [LARG-1:0] conv_bin;
  logic [7:0]      conv_bcd;
  logic            conv_passou99;
  logic [7:0]      bcd_a;
  logic [7:0]      bcd_b;
  logic            saturou_a;
  logic            saturou_b;
  logic            ocupado;
  logic            descartado;
  logic            erro_conv;
  modport slave (
    input  ponto_valido, time_sel, valor, corrigir, zerar, conv_bcd, conv_passou99,
    output conv_bin, bcd_a, bcd_b, saturou_a, saturou_b, ocupado, descartado, erro_conv
  );
  modport master (
    output ponto_valido, time_sel, valor, corrigir, zerar, conv_bcd, conv_passou99,
    input  conv_bin, bcd_a, bcd_b, saturou_a, saturou_b, ocupado, descartado, erro_conv
  );
endinterface

// File: rtl/controlador_placar.sv
// controlador_placar: score sequencer sharing one binary-to-BCD converter between two teams
module controlador_placar #(
  parameter int MAX_PLACAR = 99,
  parameter int LARG = 7
) (
  input logic clk,
  input logic rst,
  controlador_placar_if.slave p
);
  typedef enum logic [1:0] {OCIOSO, ATUALIZA, CONV_A, CONV_B} estado_t;
  estado_t state_q, state_d;
  logic [LARG-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic [7:0] bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
  logic sat_a_q, sat_a_d, sat_b_q, sat_b_d, err_q, err_d, desc_q, desc_d, buf_full_q, buf_full_d;
  logic [3:0] ev_q, ev_d, buf_q, buf_d, inc;
  logic ev_ok, sat;
  logic [7:0] cur, sum, res;
  assign inc = {p.time_sel, p.valor, p.corrigir};
  assign ev_ok = p.ponto_valido && p.valor != 2'd0;
  assign p.conv_bin = state_q == CONV_A ? score_a_q : state_q == CONV_B ? score_b_q : '0;
  assign p.bcd_a = bcd_a_q;
  assign p.bcd_b = bcd_b_q;
  assign p.saturou_a = sat_a_q;
  assign p.saturou_b = sat_b_q;
  assign p.ocupado = state_q != OCIOSO;
  assign p.descartado = desc_q;
  assign p.erro_conv = err_q;
  // 8-bit add/subtract of the latched event against the selected score, clamped to 0..MAX_PLACAR
  always_comb begin
    cur = ev_q[3] ? 8'(score_b_q) : 8'(score_a_q);
    sum = cur + 8'(ev_q[2:1]);
    sat = !ev_q[0] && sum > 8'(MAX_PLACAR);
    res = ev_q[0] ? (8'(ev_q[2:1]) > cur ? 8'd0 : cur - 8'(ev_q[2:1])) : (sat ? 8'(MAX_PLACAR) : sum);
  end
  // next state and datapath; zerar overrides everything, busy events go to the one-entry buffer
  always_comb begin
    state_d = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    bcd_a_d = bcd_a_q;
    bcd_b_d = bcd_b_q;
    sat_a_d = sat_a_q;
    sat_b_d = sat_b_q;
    err_d = err_q;
    desc_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_d = buf_q;
    ev_d = ev_q;
    if (p.zerar) begin
      state_d = CONV_A;
      score_a_d = '0;
      score_b_d = '0;
      sat_a_d = 1'b0;
      sat_b_d = 1'b0;
      err_d = 1'b0;
      buf_full_d = 1'b0;
      ev_d = '0;
    end else begin
      case (state_q)
        OCIOSO: if (ev_ok) begin
          ev_d = inc;
          state_d = ATUALIZA;
        end
        ATUALIZA: begin
          if (ev_q[3]) begin
            score_b_d = LARG'(res);
            sat_b_d = sat_b_q | sat;
          end else begin
            score_a_d = LARG'(res);
            sat_a_d = sat_a_q | sat;
          end
          state_d = CONV_A;
        end
        CONV_A: begin
          bcd_a_d = p.conv_bcd;
          err_d = err_q | p.conv_passou99;
          state_d = CONV_B;
        end
        default: begin
          bcd_b_d = p.conv_bcd;
          err_d = err_q | p.conv_passou99;
          state_d = buf_full_q || ev_ok ? ATUALIZA : OCIOSO;
          ev_d = buf_full_q ? buf_q : ev_ok ? inc : ev_q;
          desc_d = buf_full_q && ev_ok;
          buf_full_d = 1'b0;
        end
      endcase
      if ((state_q == ATUALIZA || state_q == CONV_A) && ev_ok) begin
        desc_d = buf_full_q;
        buf_full_d = 1'b1;
        buf_d = buf_full_q ? buf_q : inc;
      end
    end
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OCIOSO;
    else state_q <= state_d;
  end
  // score, display, flag and event registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_a_q <= '0;
      score_b_q <= '0;
      bcd_a_q <= '0;
      bcd_b_q <= '0;
      sat_a_q <= 1'b0;
      sat_b_q <= 1'b0;
      err_q <= 1'b0;
      desc_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q <= '0;
      ev_q <= '0;
    end else begin
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      bcd_a_q <= bcd_a_d;
      bcd_b_q <= bcd_b_d;
      sat_a_q <= sat_a_d;
      sat_b_q <= sat_b_d;
      err_q <= err_d;
      desc_q <= desc_d;
      buf_full_q <= buf_full_d;
      buf_q <= buf_d;
      ev_q <= ev_d;
    end
  end
endmodule

// File: tb/tb_controlador_placar.sv
// tb_controlador_placar: directed vector bench for the score sequencer
module tb_controlador_placar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_err = 1'b0;
  logic desc_seen = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int busy;
  controlador_placar_if #(.LARG(7)) bus ();
  controlador_placar #(.MAX_PLACAR(99), .LARG(7)) dut (.clk(clk), .rst(rst), .p(bus));
  always #5 clk = ~clk;
  assign bus.conv_bcd = {4'(bus.conv_bin / 7'd10), 4'(bus.conv_bin % 7'd10)};
  assign bus.conv_passou99 = bus.conv_bin > 7'd99 || force_err;
  always @(negedge clk) if (bus.descartado) desc_seen <= 1'b1;
  typedef struct {
    logic t;
    logic [1:0] v;
    logic c;
    int rep;
    logic [7:0] ea;
    logic [7:0] eb;
    logic sa;
    logic sb;
  } vec_t;
  vec_t tbl[10];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_event(input logic t, input logic [1:0] v, input logic c, output int b);
    bus.ponto_valido = 1'b1;
    bus.time_sel = t;
    bus.valor = v;
    bus.corrigir = c;
    tick();
    bus.ponto_valido = 1'b0;
    b = 0;
    while (bus.ocupado && b < 20) begin
      b++;
      tick();
    end
  endtask
  task automatic pulse_zerar();
    bus.zerar = 1'b1;
    tick();
    bus.zerar = 1'b0;
    for (int i = 0; i < 20 && bus.ocupado; i++) tick();
  endtask
  initial begin
    bus.ponto_valido = 1'b0;
    bus.time_sel = 1'b0;
    bus.valor = 2'd0;
    bus.corrigir = 1'b0;
    bus.zerar = 1'b0;
    tbl[0] = '{1'b0, 2'd3, 1'b0, 1,  8'h03, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'd3, 1'b0, 32, 8'h03, 8'h96, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd2, 1'b0, 1,  8'h03, 8'h98, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 1'b0, 1,  8'h03, 8'h99, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 2'd2, 1'b1, 1,  8'h03, 8'h97, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 2'd2, 1'b1, 1,  8'h01, 8'h97, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 2'd3, 1'b1, 1,  8'h00, 8'h97, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 2'd0, 1'b0, 1,  8'h00, 8'h97, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 2'd3, 1'b0, 3,  8'h09, 8'h97, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 2'd1, 1'b0, 1,  8'h10, 8'h97, 1'b0, 1'b1};
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset bcd_a", bus.bcd_a, 8'h00);
    check("reset bcd_b", bus.bcd_b, 8'h00);
    check("reset flags", {3'b0, bus.saturou_a, bus.saturou_b, bus.erro_conv, bus.descartado, bus.ocupado}, 8'h00);
    check("reset conv_bin", 8'(bus.conv_bin), 8'h00);
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) send_event(tbl[i].t, tbl[i].v, tbl[i].c, busy);
      check($sformatf("vec%0d busy", i), 8'(busy), tbl[i].v != 2'd0 ? 8'd3 : 8'd0);
      check($sformatf("vec%0d bcd_a", i), bus.bcd_a, tbl[i].ea);
      check($sformatf("vec%0d bcd_b", i), bus.bcd_b, tbl[i].eb);
      check($sformatf("vec%0d sat", i), {6'b0, bus.saturou_a, bus.saturou_b}, {6'b0, tbl[i].sa, tbl[i].sb});
    end
    check("no descartado", {7'b0, desc_seen}, 8'h00);
    pulse_zerar();
    check("zerar bcd", {bus.bcd_a | bus.bcd_b}, 8'h00);
    check("zerar sat_b", {7'b0, bus.saturou_b}, 8'h00);
    bus.ponto_valido = 1'b1;
    bus.time_sel = 1'b0;
    bus.valor = 2'd1;
    bus.corrigir = 1'b0;
    tick();
    bus.time_sel = 1'b1;
    bus.valor = 2'd2;
    tick();
    bus.time_sel = 1'b0;
    bus.valor = 2'd3;
    tick();
    bus.ponto_valido = 1'b0;
    check("b2b drop pulse", {7'b0, bus.descartado}, 8'h01);
    tick();
    check("b2b drop one cycle", {7'b0, bus.descartado}, 8'h00);
    for (int i = 0; i < 20 && bus.ocupado; i++) tick();
    check("b2b bcd_a", bus.bcd_a, 8'h01);
    check("b2b bcd_b", bus.bcd_b, 8'h02);
    pulse_zerar();
    for (int r = 0; r < 15; r++) send_event(1'b0, 2'd3, 1'b0, busy);
    check("a45 bcd_a", bus.bcd_a, 8'h45);
    bus.ponto_valido = 1'b1;
    bus.time_sel = 1'b0;
    bus.valor = 2'd1;
    tick();
    bus.ponto_valido = 1'b0;
    tick();
    bus.zerar = 1'b1;
    bus.ponto_valido = 1'b1;
    bus.time_sel = 1'b1;
    bus.valor = 2'd3;
    tick();
    bus.zerar = 1'b0;
    bus.ponto_valido = 1'b0;
    check("zerar busy", {7'b0, bus.ocupado}, 8'h01);
    tick();
    check("zerar bcd_a", bus.bcd_a, 8'h00);
    tick();
    check("zerar bcd_b", bus.bcd_b, 8'h00);
    check("zerar idle", {7'b0, bus.ocupado}, 8'h00);
    tick();
    check("zerar event ignored", {7'b0, bus.ocupado}, 8'h00);
    check("zerar flags", {4'b0, bus.saturou_a, bus.saturou_b, bus.erro_conv, bus.descartado}, 8'h00);
    bus.ponto_valido = 1'b1;
    bus.time_sel = 1'b0;
    bus.valor = 2'd1;
    tick();
    bus.ponto_valido = 1'b0;
    tick();
    check("conv_bin in CONV_A", 8'(bus.conv_bin), 8'h01);
    tick();
    force_err = 1'b1;
    tick();
    force_err = 1'b0;
    check("erro_conv set", {7'b0, bus.erro_conv}, 8'h01);
    send_event(1'b1, 2'd1, 1'b0, busy);
    check("erro_conv sticky", {7'b0, bus.erro_conv}, 8'h01);
    pulse_zerar();
    check("erro_conv cleared", {7'b0, bus.erro_conv}, 8'h00);
    send_event(1'b0, 2'd2, 1'b0, busy);
    check("pre-reset bcd_a", bus.bcd_a, 8'h02);
    bus.ponto_valido = 1'b1;
    bus.valor = 2'd3;
    tick();
    bus.ponto_valido = 1'b0;
    rst = 1'b1;
    #1;
    check("async rst bcd_a", bus.bcd_a, 8'h00);
    check("async rst ocupado", {7'b0, bus.ocupado}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    check("post rst idle", {7'b0, bus.ocupado}, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/controlador_placar.md
Name: controlador_placar

Overview:
- Sequencer for the scoreboard score path.
- Holds the binary scores of both teams (A/B) and applies point and correction events.
- Time-multiplexes the single shared combinational binary-to-BCD converter (7-bit in, 8-bit packed BCD out, over-99 flag) between the two teams.
- Latches BCD results into per-team display registers that feed the 7-segment decoders.

Parameters:
- MAX_PLACAR, 99, saturation ceiling for each score; must be ≤ 99.
- LARG, 7, binary score width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ponto_valido  in  1  single-cycle event strobe
- time_sel  in  1  target team: 0 = A, 1 = B
- valor  in  2  points 1..3; 0 = invalid
- corrigir  in  1  1 = subtract valor, 0 = add
- zerar  in  1  synchronous clear of match
- conv_bin  out  LARG  operand to shared converter
- conv_bcd  in  8  converter BCD result (combinational, same cycle)
- conv_passou99  in  1  converter over-99 flag
- bcd_a  out  8  packed BCD display value, team A
- bcd_b  out  8  packed BCD display value, team B
- saturou_a  out  1  sticky: team A clipped at MAX_PLACAR
- saturou_b  out  1  sticky: team B clipped at MAX_PLACAR
- ocupado  out  1  high whenever state ≠ OCIOSO
- descartado  out  1  one-cycle pulse: event lost, buffer full
- erro_conv  out  1  sticky: converter flagged >99 during a conversion

Behaviour:
- Reset (async, rst=1):
  - Scores, bcd_a, bcd_b, conv_bin = 0.
  - All flags = 0; pending buffer empty; state = OCIOSO.
- States: OCIOSO, ATUALIZA, CONV_A, CONV_B.
- conv_bin = score_a in CONV_A, score_b in CONV_B, 0 otherwise.
- OCIOSO:
  - Accepted event (ponto_valido=1, valor≠0): latch {time_sel, valor, corrigir}, go ATUALIZA.
  - valor=0: ignored silently.
- ATUALIZA: apply the latched event to the selected score, go CONV_A.
- CONV_A: bcd_a <= conv_bcd, go CONV_B.
- CONV_B: bcd_b <= conv_bcd. If the pending buffer is full, move it to the event latch, clear the buffer, go ATUALIZA. Else go OCIOSO.
- Latency:
  - Event sampled at edge E0 → score updated at E1 → bcd_a valid after E2 → bcd_b valid after E3.
  - ocupado is high for 3 cycles per isolated event.
- Arithmetic, computed at 8 bits:
  - Add: sum > MAX_PLACAR → score = MAX_PLACAR and set the team's saturou flag; else score = sum.
  - Subtract: valor > score → score = 0 (no flag); else score − valor.
- One-entry pending buffer:
  - A valid event arriving while ocupado=1 is stored if the buffer is empty.
  - If the buffer is full, it is dropped and descartado pulses 1 cycle.
  - An event in the CONV_B cycle counts as while-busy.
- zerar:
  - Accepted in any state; has priority over ponto_valido in the same cycle.
  - Next edge: scores = 0, saturou_a/b and erro_conv = 0, buffer emptied, event latch discarded, state = CONV_A.
  - Displays therefore refresh to 00 after two more edges.
- erro_conv is set if conv_passou99=1 in CONV_A or CONV_B. This cannot happen with correct scores, so it is a converter integrity check; it is cleared only by rst or zerar.
- rst asserted mid-sequence returns everything to reset values immediately; the in-flight event is lost.
- descartado is never asserted by ignored valor=0 events.

Test Plan:
- Reset, then one event A +3 → after 3 busy cycles: bcd_a=8'h03, bcd_b=8'h00, ocupado low again, descartado never high.
- Drive score B to 98 with events, then B +3 → score_b=99, bcd_b=8'h99, saturou_b=1; then B corrigir 2 → bcd_b=8'h97, saturou_b stays 1.
- Score A=1, A corrigir 3 → bcd_a=8'h00, saturou_a=0.
- Three back-to-back single-cycle events A+1, B+2, A+3 starting at E0:
  - 1st applied; 2nd buffered and applied right after CONV_B; 3rd dropped with descartado pulse at E2.
  - Final bcd_a=8'h01, bcd_b=8'h02.
- Score A=45, assert zerar together with ponto_valido during CONV_A → event ignored, two edges later bcd_a=bcd_b=8'h00, all flags 0.
- Force conv_passou99=1 during a CONV_B cycle → erro_conv=1 and holds until zerar; rst asserted mid-ATUALIZA → all outputs 0 asynchronously.
